mem_port_arbiter: RTL and testbench

Shares one synchronous single-port memory between the CPU instruction-fetch requester and the data requester. Sequences each access through a small FSM: latch the request, issue one memory enable cycle, wait the fixed read latency, then return a one-cycle ready pulse to the winner. Data requests have priority over instruction requests, with a starvation limit so fetch always makes progress. Sits between the pipelined core's instr/data buses and the shared RAM; the core stalls on the missing ready.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto one synchronous single-port RAM.
// Optional grant/conflict counters are enabled with MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [31:0]         stat_i_grants,
  output logic [31:0]         stat_d_grants,
  output logic [31:0]         stat_conflicts
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                own_d_q;
  logic                grant, grant_d;
  logic [SC_W-1:0]     starve_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
  logic                is_write;

  assign is_write = (wstrb_q != '0);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          grant_d = d_req && !(i_req && (starve_q == SC_W'(STARVE_LIMIT)));
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (is_write || (RD_LATENCY == 1)) state_d = S_DONE;
        else                               state_d = S_WAIT;
      end
      S_WAIT: begin
        // cnt_q reaching 1 here means it decrements to 0 on this edge
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      own_d_q   <= 1'b0;
      starve_q  <= '0;
      cnt_q     <= '0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        own_d_q <= grant_d;
        addr_q  <= grant_d ? d_addr : i_addr;
        wstrb_q <= grant_d ? d_wstrb : '0;
        if (grant_d) wdata_q <= d_wdata;
      end
      if (state_q == S_IDLE) begin
        if (!i_req || (grant && !grant_d))
          starve_q <= '0;
        else if (grant_d && (starve_q != SC_W'(STARVE_LIMIT)))
          starve_q <= starve_q + 1'b1;
      end
      if (state_q == S_ISSUE)     cnt_q <= CNT_W'(RD_LATENCY - 1);
      else if (state_q == S_WAIT) cnt_q <= cnt_q - 1'b1;
      if (i_ready)                 i_rdata_q <= mem_rdata;
      if (d_ready && !is_write)    d_rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_wstrb = mem_en ? wstrb_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign i_ready   = (state_q == S_DONE) && !own_d_q;
  assign d_ready   = (state_q == S_DONE) && own_d_q;
  // Read data is forwarded during the ready cycle, then held from the capture register
  assign i_rdata   = i_ready ? mem_rdata : i_rdata_q;
  assign d_rdata   = (d_ready && !is_write) ? mem_rdata : d_rdata_q;

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] st_i_q, st_d_q, st_c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_i_q <= '0;
      st_d_q <= '0;
      st_c_q <= '0;
    end else begin
      if (grant && !grant_d) st_i_q <= st_i_q + 1'b1;
      if (grant && grant_d)  st_d_q <= st_d_q + 1'b1;
      if ((state_q == S_IDLE) && i_req && d_req) st_c_q <= st_c_q + 1'b1;
    end
  end

  assign stat_i_grants  = st_i_q;
  assign stat_d_grants  = st_d_q;
  assign stat_conflicts = st_c_q;
`else
  assign stat_i_grants  = '0;
  assign stat_d_grants  = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut1 uses RD_LATENCY=1, dut3 uses RD_LATENCY=3, each with a small RAM model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic        mem_init;

  // dut1 signals
  logic        rst1, i_req1, d_req1;
  logic [31:0] i_addr1, d_addr1, d_wdata1;
  logic [3:0]  d_wstrb1;
  logic        i_ready1, d_ready1, mem_en1, busy1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_wstrb1;
  logic [31:0] st_i1, st_d1, st_c1;

  // dut3 signals
  logic        rst3, i_req3, d_req3;
  logic [31:0] i_addr3, d_addr3, d_wdata3;
  logic [3:0]  d_wstrb3;
  logic        i_ready3, d_ready3, mem_en3, busy3;
  logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_wstrb3;
  logic [31:0] st_i3, st_d3, st_c3;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst1),
    .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_wstrb(d_wstrb1),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1),
    .mem_rdata(mem_rdata1), .busy(busy1),
    .stat_i_grants(st_i1), .stat_d_grants(st_d1), .stat_conflicts(st_c1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst3),
    .i_req(i_req3), .i_addr(i_addr3), .i_ready(i_ready3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_wstrb(d_wstrb3),
    .d_ready(d_ready3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wstrb(mem_wstrb3),
    .mem_rdata(mem_rdata3), .busy(busy3),
    .stat_i_grants(st_i3), .stat_d_grants(st_d3), .stat_conflicts(st_c3)
  );

  // RAM model for dut1: one-cycle read latency, byte writes
  logic [31:0] mem1 [0:255];
  logic [31:0] rd1_data = 32'h0;
  logic        rd1_vld  = 1'b0;
  always @(posedge clk) begin
    rd1_vld <= 1'b0;
    if (mem_init) begin
      mem1[64] <= 32'hDEADBEEF;
      mem1[16] <= 32'h0000_0000;
    end else if (mem_en1) begin
      if (mem_wstrb1 != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb1[b]) mem1[mem_addr1[9:2]][8*b +: 8] <= mem_wdata1[8*b +: 8];
      end else begin
        rd1_data <= mem1[mem_addr1[9:2]];
        rd1_vld  <= 1'b1;
      end
    end
  end
  assign mem_rdata1 = rd1_vld ? rd1_data : 32'hBAD0_BAD0;

  // RAM model for dut3: three-cycle read pipeline, read-only
  logic [31:0] mem3 [0:255];
  logic [31:0] p3_data [0:2];
  logic        p3_vld  [0:2];
  always @(posedge clk) begin
    if (mem_init) begin
      mem3[32] <= 32'hCAFEF00D;
      mem3[33] <= 32'h11112222;
      mem3[64] <= 32'h13572468;
      for (int s = 0; s < 3; s++) begin
        p3_vld[s]  <= 1'b0;
        p3_data[s] <= 32'h0;
      end
    end else begin
      p3_vld[0]  <= mem_en3 && (mem_wstrb3 == 4'h0);
      p3_data[0] <= mem3[mem_addr3[9:2]];
      p3_vld[1]  <= p3_vld[0];
      p3_data[1] <= p3_data[0];
      p3_vld[2]  <= p3_vld[1];
      p3_data[2] <= p3_data[1];
    end
  end
  assign mem_rdata3 = p3_vld[2] ? p3_data[2] : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  string       exp_order;
  logic [7:0]  got [0:9];
  int          n_got;
  int          both_ready;

  initial begin
    mem_init = 1'b1;
    rst1 = 1'b1; rst3 = 1'b1;
    i_req1 = 0; d_req1 = 0; i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0; d_wstrb1 = 0;
    i_req3 = 0; d_req3 = 0; i_addr3 = 0; d_addr3 = 0; d_wdata3 = 0; d_wstrb3 = 0;
    tick(); tick();
    mem_init = 1'b0;
    rst1 = 1'b0; rst3 = 1'b0;

    // reset state
    chk("rst_busy1", {31'b0, busy1}, 32'd0);
    chk("rst_mem_en1", {31'b0, mem_en1}, 32'd0);
    chk("rst_mem_addr1", mem_addr1, 32'd0);
    chk("rst_mem_wstrb1", {28'b0, mem_wstrb1}, 32'd0);
    chk("rst_rdy1", {30'b0, i_ready1, d_ready1}, 32'd0);
    chk("rst_i_rdata1", i_rdata1, 32'd0);
    chk("rst_d_rdata1", d_rdata1, 32'd0);
    chk("rst_stats1", st_i1 | st_d1 | st_c1, 32'd0);
    chk("rst_busy3", {31'b0, busy3}, 32'd0);
    chk("rst_stats3", st_i3 | st_d3 | st_c3, 32'd0);

    // instruction read, latency 1
    i_req1 = 1; i_addr1 = 32'h100;
    tick();
    chk("i_rd_mem_en", {31'b0, mem_en1}, 32'd1);
    chk("i_rd_mem_addr", mem_addr1, 32'h100);
    chk("i_rd_no_early_ready", {31'b0, i_ready1}, 32'd0);
    tick();
    chk("i_rd_ready", {31'b0, i_ready1}, 32'd1);
    chk("i_rd_data", i_rdata1, 32'hDEADBEEF);
    chk("i_rd_mem_en_low", {31'b0, mem_en1}, 32'd0);
    i_req1 = 0;
    tick();
    chk("i_rd_busy_after", {31'b0, busy1}, 32'd0);
    chk("i_rd_ready_fell", {31'b0, i_ready1}, 32'd0);
    chk("i_rd_data_hold", i_rdata1, 32'hDEADBEEF);

    // data write
    d_req1 = 1; d_addr1 = 32'h40; d_wdata1 = 32'h12345678; d_wstrb1 = 4'hF;
    tick();
    chk("d_wr_mem_en", {31'b0, mem_en1}, 32'd1);
    chk("d_wr_mem_wstrb", {28'b0, mem_wstrb1}, 32'hF);
    chk("d_wr_mem_addr", mem_addr1, 32'h40);
    chk("d_wr_mem_wdata", mem_wdata1, 32'h12345678);
    tick();
    chk("d_wr_ready", {31'b0, d_ready1}, 32'd1);
    chk("d_wr_rdata_unchanged", d_rdata1, 32'd0);
    chk("d_wr_wstrb_low", {28'b0, mem_wstrb1}, 32'd0);
    d_req1 = 0; d_wstrb1 = 4'h0;
    tick();
    chk("d_wr_busy_after", {31'b0, busy1}, 32'd0);

    // data read-back of the written word
    d_req1 = 1; d_addr1 = 32'h40;
    tick();
    chk("d_rd_mem_wstrb", {28'b0, mem_wstrb1}, 32'd0);
    tick();
    chk("d_rd_ready", {31'b0, d_ready1}, 32'd1);
    chk("d_rd_data", d_rdata1, 32'h12345678);
    chk("d_rd_i_rdata_kept", i_rdata1, 32'hDEADBEEF);
    d_req1 = 0;
    tick();

    // latency 3 data read
    d_req3 = 1; d_addr3 = 32'h80;
    tick();
    chk("l3_mem_en_t1", {31'b0, mem_en3}, 32'd1);
    tick();
    chk("l3_mem_en_t2", {31'b0, mem_en3}, 32'd0);
    chk("l3_ready_t2", {31'b0, d_ready3}, 32'd0);
    tick();
    chk("l3_ready_t3", {31'b0, d_ready3}, 32'd0);
    chk("l3_mem_en_t3", {31'b0, mem_en3}, 32'd0);
    tick();
    chk("l3_ready_t4", {31'b0, d_ready3}, 32'd1);
    chk("l3_data_t4", d_rdata3, 32'hCAFEF00D);
    d_req3 = 0;
    tick();
    chk("l3_ready_fell", {31'b0, d_ready3}, 32'd0);
    chk("l3_busy_after", {31'b0, busy3}, 32'd0);

    // reset during WAIT of a read
    d_req3 = 1; d_addr3 = 32'h84;
    tick();
    tick();
    chk("rw_in_wait_busy", {31'b0, busy3}, 32'd1);
    rst3 = 1;
    tick();
    rst3 = 0; d_req3 = 0;
    chk("rw_busy", {31'b0, busy3}, 32'd0);
    chk("rw_mem_en", {31'b0, mem_en3}, 32'd0);
    chk("rw_mem_addr", mem_addr3, 32'd0);
    chk("rw_rdy", {30'b0, i_ready3, d_ready3}, 32'd0);
    chk("rw_d_rdata", d_rdata3, 32'd0);
    tick();
    chk("rw_no_ready_later", {31'b0, d_ready3}, 32'd0);
    tick();
    chk("rw_no_ready_later2", {31'b0, d_ready3}, 32'd0);
    i_req3 = 1; i_addr3 = 32'h100;
    tick();
    chk("rw_i_mem_en", {31'b0, mem_en3}, 32'd1);
    chk("rw_i_mem_addr", mem_addr3, 32'h100);
    tick();
    tick();
    chk("rw_i_not_early", {31'b0, i_ready3}, 32'd0);
    tick();
    chk("rw_i_ready", {31'b0, i_ready3}, 32'd1);
    chk("rw_i_data", i_rdata3, 32'h13572468);
    i_req3 = 0;
    tick();

    // starvation limit with both requests held
    rst1 = 1;
    tick();
    rst1 = 0;
    i_req1 = 1; i_addr1 = 32'h100;
    d_req1 = 1; d_addr1 = 32'h40; d_wstrb1 = 4'h0;
    n_got = 0; both_ready = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (i_ready1 && d_ready1) both_ready++;
      if (n_got < 10) begin
        if (i_ready1) begin got[n_got] = "I"; n_got++; end
        else if (d_ready1) begin got[n_got] = "D"; n_got++; end
      end
    end
    i_req1 = 0; d_req1 = 0;
    chk("sv_grant_count", n_got, 32'd10);
    chk("sv_both_ready", both_ready, 32'd0);
    exp_order = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++)
      chk($sformatf("sv_order_%0d", k), {24'b0, got[k]}, {24'b0, exp_order[k]});
`ifdef MEM_PORT_ARBITER_STATS_EN
    chk("sv_stat_d", st_d1, 32'd8);
    chk("sv_stat_i", st_i1, 32'd2);
    chk("sv_stat_c", st_c1, 32'd10);
`else
    chk("sv_stat_d", st_d1, 32'd0);
    chk("sv_stat_i", st_i1, 32'd0);
    chk("sv_stat_c", st_c1, 32'd0);
`endif
    tick();
    chk("sv_idle", {31'b0, busy1}, 32'd0);

    // simultaneous requests from IDLE with starve count clear
    i_req1 = 1; i_addr1 = 32'h100;
    d_req1 = 1; d_addr1 = 32'h40;
    tick();
    chk("sim_d_addr", mem_addr1, 32'h40);
    tick();
    chk("sim_d_ready", {31'b0, d_ready1}, 32'd1);
    chk("sim_i_not_ready", {31'b0, i_ready1}, 32'd0);
    d_req1 = 0;
    tick();
    chk("sim_i_pending", {31'b0, i_ready1}, 32'd0);
    tick();
    chk("sim_i_addr", mem_addr1, 32'h100);
    tick();
    chk("sim_i_ready", {31'b0, i_ready1}, 32'd1);
    chk("sim_i_data", i_rdata1, 32'hDEADBEEF);
    i_req1 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
